trunc_err_monitor: RTL
======================

Name: trunc_err_monitor

Overview:
- Streaming error-metric engine for the approximate-adder evaluation flow.
- Consumes operand pairs (a, b) together with the approximate sum produced by a truncated adder under test.
- Recomputes the exact sum and accumulates error statistics over a programmed number of samples: total error distance, max error distance, erroneous-sample count and LSB-violation flag.
- Sits downstream of the adder in the characterisation bench and hardware harness; it is the consumer side of the adder's output stream.

Parameters:
N, 8, operand/approx-sum width
T, 4, truncated LSB count of the adder under test (0 <= T < N)
CNT_W, 16, sample-counter width
ACC_W, N+1+CNT_W, error-distance accumulator width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: clear stats, begin a run
n_samples  in  CNT_W  samples per run, sampled on start
in_valid  in  1  sample valid
in_ready  out  1  monitor accepts sample
in_a  in  N  operand a
in_b  in  N  operand b
in_approx  in  N  approximate sum from adder under test
busy  out  1  run in progress (RUN or DRAIN)
done  out  1  stats final; held until next start or rst
sum_ed  out  ACC_W  saturating sum of error distances
max_ed  out  N+1  largest error distance seen
err_cnt  out  CNT_W  samples with nonzero error distance
lsb_viol  out  1  sticky: some in_approx[T-1:0] != 0
acc_sat  out  1  sticky: sum_ed saturated

Behaviour:
- Reset is synchronous and active-high on rst; single clock clk.
- Reset values: all outputs 0, in_ready=0, FSM=IDLE. A reset mid-run aborts the run and clears all stats and pipeline valids.
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE: in_ready=0. start with n_samples!=0 goes to RUN and clears stats. start with n_samples==0 goes to DONE with stats 0.
- RUN: in_ready=1. A transfer occurs when in_valid && in_ready. The accepted counter increments per transfer. On the transfer that makes accepted==n_samples, in_ready drops the next cycle and the FSM goes to DRAIN.
- DRAIN: in_ready=0. The FSM waits until both pipeline stages are empty (2 cycles), then goes to DONE and asserts done.
- DONE: done=1 and stats are frozen. start clears stats and done (same behaviour as from IDLE).
- start while busy is ignored.
- Pipeline stage 1 (registered on transfer):
  - exact = a + b at N+1 bits.
  - ed = |exact - zero-extended approx| at N+1 bits.
  - nz = (ed != 0).
  - lv = (approx[T-1:0] != 0). When T==0, lv is constant 0.
- Pipeline stage 2 (when stage-1 valid):
  - sum_ed += ed, saturating at all-ones; acc_sat is set on saturation.
  - max_ed = max(max_ed, ed).
  - err_cnt += nz.
  - lsb_viol |= lv.
- Latency: a sample's contribution is visible in the outputs 2 cycles after its transfer. done rises on the cycle after the last contribution.
- Back-to-back transfers at 1 sample/cycle are supported. Gaps in in_valid are allowed. Stats stay visible (live) during RUN.
- err_cnt cannot overflow because it is bounded by n_samples.

Decomposition:
- Shared package (trunc_eval_pkg):
  - FSM state enum (IDLE/RUN/DRAIN/DONE).
  - Default N/T/CNT_W constants shared with the adder benches.
  - ACC_W derivation function.
- One sub-module is natural: trunc_err_calc. It is a combinational exact-sum / abs-difference / LSB-check unit, registered by the parent as stage 1.

Test Plan (N=8, T=4):
- Single sample: start, n_samples=1; a=0x0F, b=0x01, approx=0x00. Result: sum_ed=16, max_ed=16, err_cnt=1, lsb_viol=0, done 3 cycles after transfer.
- Overflow case: a=0xFF, b=0xFF, approx=0xE0. Result: exact=0x1FE, ed=286, max_ed=286.
- Exact stream: 4 samples with zero LSBs (e.g. a=0x20, b=0x30, approx=0x50) back-to-back. Result: sum_ed=0, err_cnt=0; in_ready deasserts after the 4th transfer.
- LSB violation: a=0x10, b=0x10, approx=0x21. Result: lsb_viol=1 (sticky), ed=1.
- Control corners:
  - start with n_samples=0 gives done next cycle with all stats 0.
  - start during RUN is ignored.
  - rst asserted mid-run clears all outputs and returns to IDLE.
- Saturation: a reduced-ACC_W build (ACC_W=10) fed 4 samples of ed=286. Result: sum_ed=1023, acc_sat=1.

Source files
------------

// File: rtl/trunc_eval_pkg.sv
// Types and defaults shared by the truncated-adder evaluation blocks and benches.
package trunc_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  localparam int DEF_N     = 8;
  localparam int DEF_T     = 4;
  localparam int DEF_CNT_W = 16;

  // Wide enough to sum 2^cnt_w error distances of n+1 bits without wrapping.
  function automatic int acc_w_f(input int n, input int cnt_w);
    return n + 1 + cnt_w;
  endfunction

endpackage

// File: rtl/trunc_err_calc.sv
// Combinational exact-sum, error-distance and truncated-LSB check for one sample.
module trunc_err_calc #(
  parameter int N = 8,
  parameter int T = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] approx,
  output logic [N:0]   exact,
  output logic [N:0]   ed,
  output logic         nz,
  output logic         lv
);

  logic [N:0] approx_x;

  always_comb begin
    exact    = {1'b0, a} + {1'b0, b};
    approx_x = {1'b0, approx};
    if (exact >= approx_x) begin
      ed = exact - approx_x;
    end else begin
      ed = approx_x - exact;
    end
    nz = |ed;
  end

  // A truncated adder must leave its low T result bits at zero.
  generate
    if (T == 0) begin : g_no_trunc
      assign lv = 1'b0;
    end else begin : g_trunc
      assign lv = |approx[T-1:0];
    end
  endgenerate

endmodule

// File: rtl/trunc_err_monitor.sv
// Streaming error-metric monitor: two-stage pipeline feeding run statistics
// for a truncated adder under test, sequenced by a small run FSM.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no run since reset; waiting for start
// ST_RUN   | accepting samples until n_samples have transferred
// ST_DRAIN | input closed; waiting for stage 1 to empty into the stats
// ST_DONE  | stats final and frozen; start begins a new run
module trunc_err_monitor
  import trunc_eval_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int T     = DEF_T,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = acc_w_f(N, CNT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [N-1:0]     in_approx,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_ed,
  output logic [N:0]       max_ed,
  output logic [CNT_W-1:0] err_cnt,
  output logic             lsb_viol,
  output logic             acc_sat
);

  localparam int ACC_W1 = ACC_W + 1;

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] remain_q;
  logic             xfer;
  logic             last_xfer;
  logic             start_ok;

  logic [N:0]       calc_exact;
  logic [N:0]       calc_ed;
  logic             calc_nz;
  logic             calc_lv;

  logic             s1_valid_q;
  logic [N:0]       s1_ed_q;
  logic             s1_nz_q;
  logic             s1_lv_q;

  logic [ACC_W:0]   sum_ext;

  trunc_err_calc #(
    .N (N),
    .T (T)
  ) u_calc (
    .a      (in_a),
    .b      (in_b),
    .approx (in_approx),
    .exact  (calc_exact),
    .ed     (calc_ed),
    .nz     (calc_nz),
    .lv     (calc_lv)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    start_ok  = 1'b0;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          start_ok = 1'b1;
          state_d  = (n_samples == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        in_ready  = 1'b1;
        busy      = 1'b1;
        xfer      = in_valid;
        last_xfer = in_valid && (remain_q == CNT_W'(1));
        if (last_xfer) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Stage 2 commits in the same edge stage 1 empties, so only stage 1 is watched.
        if (!s1_valid_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        remain_q <= n_samples;
      end else if (xfer) begin
        remain_q <= remain_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ed_q    <= '0;
      s1_nz_q    <= 1'b0;
      s1_lv_q    <= 1'b0;
    end else begin
      s1_valid_q <= xfer;
      if (xfer) begin
        s1_ed_q <= calc_ed;
        s1_nz_q <= calc_nz;
        s1_lv_q <= calc_lv;
      end
    end
  end

  assign sum_ext = {1'b0, sum_ed} + ACC_W1'(s1_ed_q);

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      sum_ed   <= '0;
      max_ed   <= '0;
      err_cnt  <= '0;
      lsb_viol <= 1'b0;
      acc_sat  <= 1'b0;
    end else if (s1_valid_q) begin
      if (sum_ext[ACC_W]) begin
        sum_ed  <= '1;
        acc_sat <= 1'b1;
      end else begin
        sum_ed <= sum_ext[ACC_W-1:0];
      end
      if (s1_ed_q > max_ed) begin
        max_ed <= s1_ed_q;
      end
      err_cnt  <= err_cnt + CNT_W'(s1_nz_q);
      lsb_viol <= lsb_viol | s1_lv_q;
    end
  end

endmodule
